// File: rtl/logic_response_checker.sv
// Response checker for a gate/ALU slice: compares each accepted (a, b, y) sample against the golden op.
// Optional first-mismatch log is enabled by defining LRC_ERR_LOG_EN.
module logic_response_checker #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [WIDTH-1:0] first_fail_exp,
    output logic [WIDTH-1:0] first_fail_y
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [2:0]       r_op;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic [WIDTH-1:0] w_expected;
    logic             w_match;
    logic             w_hs;
    logic             w_start_ok;
    logic             w_last;

    // Golden result is the only combinational path from the sample inputs.
    always_comb begin
        w_expected = '0;
        case (r_op)
            3'b000:  w_expected = a & b;
            3'b001:  w_expected = a | b;
            3'b010:  w_expected = a ^ b;
            3'b011:  w_expected = ~(a & b);
            3'b100:  w_expected = ~(a | b);
            3'b101:  w_expected = ~(a ^ b);
            3'b110:  w_expected = ~a;
            default: w_expected = a;
        endcase
    end

    assign w_match    = (y == w_expected);
    assign w_hs       = in_valid && (r_state == S_RUN);
    assign w_start_ok = start && (r_state != S_RUN);
    // Widened compare so the final index never needs to wrap.
    assign w_last     = (({1'b0, r_idx} + (CNT_W+1)'(1)) == {1'b0, r_num});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_next = (num_vectors == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_hs && w_last) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op       <= '0;
            r_num      <= '0;
            r_idx      <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
        end else if (w_start_ok) begin
            r_op       <= op;
            r_num      <= num_vectors;
            r_idx      <= '0;
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
        end else if (w_hs) begin
            r_idx <= r_idx + CNT_W'(1);
            if (w_match) begin
                if (r_pass_cnt != '1) begin
                    r_pass_cnt <= r_pass_cnt + CNT_W'(1);
                end
            end else begin
                if (r_fail_cnt != '1) begin
                    r_fail_cnt <= r_fail_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign in_ready = (r_state == S_RUN);
    assign busy     = (r_state == S_RUN);
    assign done     = (r_state == S_DONE);
    assign pass     = (r_state == S_DONE) && (r_fail_cnt == '0);
    assign pass_cnt = r_pass_cnt;
    assign fail_cnt = r_fail_cnt;

`ifdef LRC_ERR_LOG_EN
    logic [CNT_W-1:0] r_ff_idx;
    logic [WIDTH-1:0] r_ff_exp;
    logic [WIDTH-1:0] r_ff_y;

    // A zero fail count marks that no mismatch has been logged yet in this run.
    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_ff_idx <= '0;
            r_ff_exp <= '0;
            r_ff_y   <= '0;
        end else if (w_hs && !w_match && (r_fail_cnt == '0)) begin
            r_ff_idx <= r_idx;
            r_ff_exp <= w_expected;
            r_ff_y   <= y;
        end
    end

    assign first_fail_idx = r_ff_idx;
    assign first_fail_exp = r_ff_exp;
    assign first_fail_y   = r_ff_y;
`else
    assign first_fail_idx = '0;
    assign first_fail_exp = '0;
    assign first_fail_y   = '0;
`endif

endmodule

// File: tb/tb_logic_response_checker.sv
// Randomized self-checking bench for logic_response_checker against a cycle-level behavioural model.
module tb_logic_response_checker;

    localparam int WIDTH = 8;
    localparam int CNT_W = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2:0]       op;
    logic [CNT_W-1:0] num_vectors;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b, y;
    logic             busy, done, pass;
    logic [CNT_W-1:0] pass_cnt, fail_cnt, first_fail_idx;
    logic [WIDTH-1:0] first_fail_exp, first_fail_y;

    always #5 clk = ~clk;

    logic_response_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .num_vectors(num_vectors),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .y(y),
        .busy(busy), .done(done), .pass(pass), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail_idx(first_fail_idx), .first_fail_exp(first_fail_exp),
        .first_fail_y(first_fail_y)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: 0 idle, 1 running, 2 finished.
    int         m_state;
    logic [2:0] m_op;
    int         m_n, m_idx, m_pass, m_fail;
    logic       m_logged;
    int         m_ff_idx;
    logic [7:0] m_ff_exp, m_ff_y;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    // Each op is a 2-input truth table indexed by {a_bit, b_bit}, applied bit by bit.
    function automatic logic [7:0] golden(input logic [2:0] gop, input logic [7:0] ga, input logic [7:0] gb);
        logic [3:0] tt;
        logic [7:0] r;
        case (gop)
            3'd0:    tt = 4'b1000;
            3'd1:    tt = 4'b1110;
            3'd2:    tt = 4'b0110;
            3'd3:    tt = 4'b0111;
            3'd4:    tt = 4'b0001;
            3'd5:    tt = 4'b1001;
            3'd6:    tt = 4'b0011;
            default: tt = 4'b1100;
        endcase
        for (int i = 0; i < 8; i++) r[i] = tt[{ga[i], gb[i]}];
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, ":busy"},     busy,     m_state == 1);
        check_eq({tag, ":in_ready"}, in_ready, m_state == 1);
        check_eq({tag, ":done"},     done,     m_state == 2);
        check_eq({tag, ":pass"},     pass,     (m_state == 2) && (m_fail == 0));
        check_eq({tag, ":pass_cnt"}, pass_cnt, m_pass);
        check_eq({tag, ":fail_cnt"}, fail_cnt, m_fail);
`ifdef LRC_ERR_LOG_EN
        check_eq({tag, ":ff_idx"},   first_fail_idx, m_ff_idx);
        check_eq({tag, ":ff_exp"},   first_fail_exp, m_ff_exp);
        check_eq({tag, ":ff_y"},     first_fail_y,   m_ff_y);
`else
        check_eq({tag, ":ff_idx"},   first_fail_idx, 0);
        check_eq({tag, ":ff_exp"},   first_fail_exp, 0);
        check_eq({tag, ":ff_y"},     first_fail_y,   0);
`endif
    endtask

    // Apply the currently driven inputs for one clock, advance the model, then compare.
    task automatic cycle(input string tag);
        logic [7:0] e;
        if (rst) begin
            m_state = 0; m_idx = 0; m_pass = 0; m_fail = 0; m_n = 0;
            m_logged = 1'b0; m_ff_idx = 0; m_ff_exp = '0; m_ff_y = '0;
        end else if (start && m_state != 1) begin
            m_op = op; m_n = int'(num_vectors);
            m_idx = 0; m_pass = 0; m_fail = 0;
            m_logged = 1'b0; m_ff_idx = 0; m_ff_exp = '0; m_ff_y = '0;
            m_state = (m_n == 0) ? 2 : 1;
        end else if (m_state == 1 && in_valid) begin
            e = golden(m_op, a, b);
            if (y == e) begin
                if (m_pass < CNT_MAX) m_pass++;
            end else begin
                if (!m_logged) begin
                    m_logged = 1'b1; m_ff_idx = m_idx; m_ff_exp = e; m_ff_y = y;
                end
                if (m_fail < CNT_MAX) m_fail++;
            end
            $display("[%0t] %s idx=%0d op=%0d a=%h b=%h y=%h exp=%h %s",
                     $time, tag, m_idx, m_op, a, b, y, e, (y == e) ? "match" : "miss");
            m_idx++;
            if (m_idx == m_n) m_state = 2;
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic do_start(input logic [2:0] sop, input int n, input string tag);
        start = 1'b1; op = sop; num_vectors = CNT_W'(n);
        cycle(tag);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] sa, input logic [7:0] sb, input logic [7:0] sy, input string tag);
        in_valid = 1'b1; a = sa; b = sb; y = sy;
        cycle(tag);
        in_valid = 1'b0;
    endtask

    task automatic run_random(input logic [2:0] rop, input int n, input int gap_pct,
                              input int err_pct, input string tag);
        do_start(rop, n, tag);
        for (int k = 0; k < n * 8 + 16 && m_state == 1; k++) begin
            in_valid = ($urandom_range(99) >= gap_pct);
            a = 8'($urandom);
            b = 8'($urandom);
            y = golden(rop, a, b);
            if ($urandom_range(99) < err_pct) y = y ^ 8'($urandom_range(255, 1));
            cycle(tag);
        end
        check_eq({tag, ":finished"}, done, 1);
        // A sample offered after completion must not be counted.
        in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); y = 8'($urandom);
        cycle({tag, "_after"});
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; num_vectors = '0;
        in_valid = 1'b0; a = '0; b = '0; y = '0;
        m_state = 0; m_op = '0; m_n = 0; m_idx = 0; m_pass = 0; m_fail = 0;
        m_logged = 1'b0; m_ff_idx = 0; m_ff_exp = '0; m_ff_y = '0;

        cycle("reset");
        cycle("reset");
        rst = 1'b0;
        cycle("idle");
        in_valid = 1'b1;
        cycle("idle_valid");
        in_valid = 1'b0;

        // Directed AND run, all samples correct.
        do_start(3'b000, 4, "t1");
        send(8'hF0, 8'h3C, 8'h30, "t1");
        send(8'hFF, 8'h00, 8'h00, "t1");
        send(8'hAA, 8'h55, 8'h00, "t1");
        send(8'h0F, 8'h0F, 8'h0F, "t1");
        check_eq("t1_done", done, 1);
        check_eq("t1_pass", pass, 1);
        check_eq("t1_pass_cnt", pass_cnt, 4);
        check_eq("t1_fail_cnt", fail_cnt, 0);

        // XOR run with a single wrong second sample.
        do_start(3'b010, 3, "t2");
        send(8'hF0, 8'hFF, 8'h0F, "t2");
        send(8'hF0, 8'hFF, 8'hFF, "t2");
        send(8'h12, 8'h34, 8'h26, "t2");
        check_eq("t2_fail_cnt", fail_cnt, 1);
        check_eq("t2_pass", pass, 0);
`ifdef LRC_ERR_LOG_EN
        check_eq("t2_ff_idx", first_fail_idx, 1);
        check_eq("t2_ff_exp", first_fail_exp, 8'h0F);
        check_eq("t2_ff_y",   first_fail_y,   8'hFF);
`endif

        // Random gaps with N=5.
        run_random(3'($urandom_range(7)), 5, 50, 30, "t3");
        check_eq("t3_total", 32'(pass_cnt) + 32'(fail_cnt), 5);

        // Reset in the middle of a run.
        do_start(3'b001, 6, "t5");
        send(8'h01, 8'h02, 8'h03, "t5");
        send(8'h10, 8'h20, 8'h00, "t5");
        rst = 1'b1;
        cycle("t5_rst");
        rst = 1'b0;
        check_eq("t5_pass_cnt", pass_cnt, 0);
        check_eq("t5_busy", busy, 0);

        // Zero-length run.
        do_start(3'b101, 0, "t4");
        check_eq("t4_done", done, 1);
        check_eq("t4_pass", pass, 1);

        // Start during a run is ignored; restart from DONE clears counters.
        do_start(3'b110, 3, "t6");
        send(8'h3C, 8'h00, 8'hC3, "t6");
        check_eq("t6_not_pass_cnt", pass_cnt, 1);
        start = 1'b1; op = 3'b000; num_vectors = CNT_W'(1);
        cycle("t6_ign");
        start = 1'b0;
        send(8'hA5, 8'hFF, 8'h5A, "t6");
        send(8'h00, 8'h12, 8'h00, "t6");
        check_eq("t6_fail_cnt", fail_cnt, 1);
        do_start(3'b111, 2, "t6_re");
        check_eq("t6_re_pass_cnt", pass_cnt, 0);
        check_eq("t6_re_done", done, 0);
        send(8'h5A, 8'h00, 8'h5A, "t6_re");
        send(8'h77, 8'hFF, 8'h77, "t6_re");

        // Randomized runs across all ops.
        for (int r = 0; r < 10; r++) begin
            run_random(3'($urandom_range(7)), int'($urandom_range(12, 1)),
                       int'($urandom_range(60)), int'($urandom_range(40)), "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
